// File: rtl/uart_rx.sv
// UART receiver: 8x-prescaled bit timing, LSB-first, AXI-Stream style output with overrun and frame error pulses.
// Define UART_RX_SYNC_EN to put a 2-flop synchroniser on rxd (adds 2 cycles to every latency).
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int CW = 19;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // state          | meaning
    // IDLE           | line idle, waiting for a low sample
    // RECEIVE_START  | half-bit wait, then confirm the start bit
    // RECEIVE_DATA   | sampling payload bits at mid-bit
    // RECEIVE_STOP   | sampling the stop bit
    // WAIT_HIGH      | after a bad stop bit, wait for the line to return high
    typedef enum logic [3:0] {
        IDLE          = 4'b0000,
        RECEIVE_START = 4'b0001,
        RECEIVE_DATA  = 4'b0010,
        RECEIVE_STOP  = 4'b0100,
        WAIT_HIGH     = 4'b1000
    } state_t;

    logic rxd_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rxd};
    end
    assign rxd_s = sync_q[1];
`else
    assign rxd_s = rxd;
`endif

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         t_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_q;
    logic                  armed_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  overrun_q;
    logic                  frame_q;

    logic [15:0]   presc_eff;
    logic [CW-1:0] t_live;
    logic [CW-1:0] half_live;

    assign presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    assign t_live    = {presc_eff, 3'b000};
    assign half_live = {1'b0, presc_eff, 2'b00} - CW'(1);

    // armed_q blocks a start until the line has been seen high, so a reset
    // in the middle of a low bit cannot be mistaken for a new start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            t_q       <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            armed_q   <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            if (rxd_s) armed_q <= 1'b1;
            if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rxd_s && armed_q) begin
                        state_q <= RECEIVE_START;
                        cnt_q   <= half_live;
                        t_q     <= t_live;
                    end
                end
                RECEIVE_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rxd_s) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RECEIVE_DATA;
                        cnt_q   <= t_q - CW'(1);
                        bit_q   <= '0;
                    end
                end
                RECEIVE_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        shift_q <= (shift_q >> 1) | (DATA_WIDTH'(rxd_s) << (DATA_WIDTH - 1));
                        cnt_q   <= t_q - CW'(1);
                        if (bit_q == BW'(DATA_WIDTH - 1)) state_q <= RECEIVE_STOP;
                        else                             bit_q   <= bit_q + BW'(1);
                    end
                end
                RECEIVE_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rxd_s) begin
                        state_q <= IDLE;
                        // A handshake this cycle frees the slot, so the new byte wins.
                        if (tvalid_q && !m_axis_tready) begin
                            overrun_q <= 1'b1;
                        end else begin
                            tdata_q  <= shift_q;
                            tvalid_q <= 1'b1;
                        end
                    end else begin
                        frame_q <= 1'b1;
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun_error = overrun_q;
    assign frame_error   = frame_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at prescale=1 (T=8); cycle 0 is the first low rxd cycle of each scenario.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;

    int ncmp = 0;
    int nerr = 0;
    logic any_fe, any_ov, any_tv;
    int   n_ov;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level of a T=8 frame at cycle c relative to the start bit.
    function automatic logic lvl(input logic [7:0] d, input logic stop, input int c);
        if (c < 8)       return 1'b0;
        else if (c < 72) return d[(c - 8) / 8];
        else if (c < 80) return stop;
        else             return 1'b1;
    endfunction

    task automatic clr_sticky();
        any_fe = 1'b0;
        any_ov = 1'b0;
        any_tv = 1'b0;
        n_ov   = 0;
    endtask

    task automatic upd_sticky();
        any_fe = any_fe | frame_error;
        any_ov = any_ov | overrun_error;
        any_tv = any_tv | m_axis_tvalid;
        n_ov   = n_ov + int'(overrun_error);
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        m_axis_tready = 1'b1;
        prescale = 16'd1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ovr", overrun_error, 0);
        tick();
        rst = 1'b1;
        repeat (6) tick();

        // Good frame 0xA5, always ready
        clr_sticky();
        for (int c = 0; c < 90; c++) begin
            rxd = lvl(8'hA5, 1'b1, c);
            @(negedge clk);
            upd_sticky();
            if (c == 0)      chk("s1_busy_c0", busy, 0);
            if (c == 1 + S)  chk("s1_busy_start", busy, 1);
            if (c == 76 + S) chk("s1_tvalid_early", m_axis_tvalid, 0);
            if (c == 77 + S) begin
                chk("s1_tvalid", m_axis_tvalid, 1);
                chk("s1_tdata", m_axis_tdata, 8'hA5);
                chk("s1_busy_end", busy, 0);
            end
            if (c == 78 + S) chk("s1_tvalid_drop", m_axis_tvalid, 0);
            tick();
        end
        chk("s1_no_ferr", any_fe, 0);
        chk("s1_no_ovr", any_ov, 0);

        // False start: 3 low cycles
        clr_sticky();
        for (int c = 0; c < 16; c++) begin
            rxd = (c < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            upd_sticky();
            if (c == 4 + S) chk("s2_busy_sample", busy, 1);
            if (c == 5 + S) chk("s2_idle", busy, 0);
            tick();
        end
        chk("s2_no_tvalid", any_tv, 0);
        chk("s2_no_ferr", any_fe, 0);
        chk("s2_no_ovr", any_ov, 0);

        // Bad stop bit on 0x3C, line held low through cycle 99
        clr_sticky();
        for (int c = 0; c < 110; c++) begin
            rxd = (c < 72) ? lvl(8'h3C, 1'b0, c) : ((c < 100) ? 1'b0 : 1'b1);
            @(negedge clk);
            upd_sticky();
            if (c == 76 + S) chk("s3_ferr_early", frame_error, 0);
            if (c == 77 + S) begin
                chk("s3_ferr", frame_error, 1);
                chk("s3_busy_wait", busy, 1);
            end
            if (c == 78 + S)  chk("s3_ferr_pulse", frame_error, 0);
            if (c == 100 + S) chk("s3_busy_held", busy, 1);
            if (c == 101 + S) chk("s3_busy_release", busy, 0);
            tick();
        end
        chk("s3_no_tvalid", any_tv, 0);
        chk("s3_no_ovr", any_ov, 0);

        // 0x11 then 0x22 back-to-back, not ready
        clr_sticky();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 170; c++) begin
            rxd = (c < 80) ? lvl(8'h11, 1'b1, c) : lvl(8'h22, 1'b1, c - 80);
            @(negedge clk);
            upd_sticky();
            if (c == 77 + S) begin
                chk("s4_tvalid1", m_axis_tvalid, 1);
                chk("s4_tdata1", m_axis_tdata, 8'h11);
            end
            if (c == 156 + S) chk("s4_ovr_early", overrun_error, 0);
            if (c == 157 + S) begin
                chk("s4_ovr", overrun_error, 1);
                chk("s4_tdata_kept", m_axis_tdata, 8'h11);
                chk("s4_tvalid_kept", m_axis_tvalid, 1);
            end
            tick();
        end
        chk("s4_ovr_count", n_ov, 1);
        chk("s4_no_ferr", any_fe, 0);
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("s4_hs_tvalid", m_axis_tvalid, 1);
        chk("s4_hs_tdata", m_axis_tdata, 8'h11);
        tick();
        @(negedge clk);
        chk("s4_after_hs", m_axis_tvalid, 0);
        repeat (4) tick();

        // Reset at cycle 40 of a 0xF5 frame
        clr_sticky();
        for (int c = 0; c < 140; c++) begin
            rxd = lvl(8'hF5, 1'b1, c);
            rst = (c == 40) ? 1'b0 : 1'b1;
            @(negedge clk);
            upd_sticky();
            if (c == 39) chk("s5_busy_pre", busy, 1);
            if (c == 41) begin
                chk("s5_busy_rst", busy, 0);
                chk("s5_tvalid_rst", m_axis_tvalid, 0);
            end
            if (c == 90) chk("s5_busy_later", busy, 0);
            tick();
        end
        chk("s5_no_tvalid", any_tv, 0);
        chk("s5_no_ferr", any_fe, 0);
        chk("s5_no_ovr", any_ov, 0);

        // 0x5A with prescale=0 (acts as 1), changed mid-frame to 5
        clr_sticky();
        prescale = 16'd0;
        for (int c = 0; c < 90; c++) begin
            rxd = lvl(8'h5A, 1'b1, c);
            if (c == 30) prescale = 16'd5;
            @(negedge clk);
            upd_sticky();
            if (c == 76 + S) chk("s6_tvalid_early", m_axis_tvalid, 0);
            if (c == 77 + S) begin
                chk("s6_tvalid", m_axis_tvalid, 1);
                chk("s6_tdata", m_axis_tdata, 8'h5A);
            end
            tick();
        end
        chk("s6_no_ferr", any_fe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
